// File: rtl/button_pkg.sv
// Shared state encoding and default timing constants for the push-button input path.
package button_pkg;

   typedef enum logic [1:0] {
      ST_UP        = 2'd0,
      ST_WAIT_DOWN = 2'd1,
      ST_DOWN      = 2'd2,
      ST_WAIT_UP   = 2'd3
   } btn_state_e;

   localparam int CLK_HZ = 24_000_000;
   // ~10 ms debounce window and ~1 s long-press hold at the board clock
   localparam int DEBOUNCE_CYCLES_DEFAULT   = CLK_HZ / 100;
   localparam int LONG_PRESS_CYCLES_DEFAULT = CLK_HZ;

endpackage

// File: rtl/button_debounce.sv
// One active-low push button: 2-flop synchroniser, debounce FSM, press/release/toggle outputs.
// Optional long-press pulse enabled by defining BUTTON_INPUT_LONG_PRESS_EN.
module button_debounce
   import button_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
   parameter int   LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT,
   parameter logic TOGGLE_INIT       = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic level,
   output logic pressed,
   output logic released,
   output logic toggle,
   output logic long_press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             s;
   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             pressed_q, pressed_d;
   logic             released_q, released_d;
   logic             toggle_q, toggle_d;
   logic             long_press_q, long_press_d;

   // Reset value of the chain is "released", so a held button is seen as a fresh press
   assign s = ~sync_q[1];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      level_d    = level_q;
      pressed_d  = 1'b0;
      released_d = 1'b0;
      toggle_d   = toggle_q;
      case (state_q)
         ST_UP: begin
            if (s) begin
               state_d = ST_WAIT_DOWN;
               cnt_d   = '0;
            end
         end
         ST_WAIT_DOWN: begin
            if (!s) begin
               state_d = ST_UP;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ST_DOWN;
               cnt_d     = '0;
               pressed_d = 1'b1;
               level_d   = 1'b1;
               toggle_d  = ~toggle_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DOWN: begin
            if (!s) begin
               state_d = ST_WAIT_UP;
               cnt_d   = '0;
            end
         end
         ST_WAIT_UP: begin
            if (s) begin
               state_d = ST_DOWN;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d    = ST_UP;
               cnt_d      = '0;
               released_d = 1'b1;
               level_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_UP;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef BUTTON_INPUT_LONG_PRESS_EN
   localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              lp_done_q, lp_done_d;

   // Hold timer only advances while staying in DOWN; lp_done limits it to one pulse per press
   always_comb begin
      hold_d       = hold_q;
      lp_done_d    = lp_done_q;
      long_press_d = 1'b0;
      if (state_q == ST_DOWN && s) begin
         if (!lp_done_q) begin
            if (hold_q == HOLD_LAST) begin
               long_press_d = 1'b1;
               lp_done_d    = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
      end else begin
         hold_d    = '0;
         lp_done_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q    <= '0;
         lp_done_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         lp_done_q <= lp_done_d;
      end
   end
`else
   assign long_press_d = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q       <= 2'b11;
         state_q      <= ST_UP;
         cnt_q        <= '0;
         level_q      <= 1'b0;
         pressed_q    <= 1'b0;
         released_q   <= 1'b0;
         toggle_q     <= TOGGLE_INIT;
         long_press_q <= 1'b0;
      end else begin
         sync_q       <= {sync_q[0], btn_n};
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         level_q      <= level_d;
         pressed_q    <= pressed_d;
         released_q   <= released_d;
         toggle_q     <= toggle_d;
         long_press_q <= long_press_d;
      end
   end

   assign level      = level_q;
   assign pressed    = pressed_q;
   assign released   = released_q;
   assign toggle     = toggle_q;
   assign long_press = long_press_q;

endmodule

// File: rtl/button_input.sv
// N_BTN independent debounced push buttons; toggle bits drive the LED colour enables directly.
// long_press is live only when BUTTON_INPUT_LONG_PRESS_EN is defined, otherwise held at 0.
module button_input
   import button_pkg::*;
#(
   parameter int               N_BTN             = 2,
   parameter int               DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
   parameter logic [N_BTN-1:0] TOGGLE_INIT       = {N_BTN{1'b0}},
   parameter int               LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_n,
   output logic [N_BTN-1:0] level,
   output logic [N_BTN-1:0] pressed,
   output logic [N_BTN-1:0] released,
   output logic [N_BTN-1:0] toggle,
   output logic [N_BTN-1:0] long_press
);

   genvar gi;
   generate
      for (gi = 0; gi < N_BTN; gi++) begin : g_btn
         button_debounce #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .TOGGLE_INIT      (TOGGLE_INIT[gi])
         ) u_debounce (
            .clk       (clk),
            .reset     (reset),
            .btn_n     (btn_n[gi]),
            .level     (level[gi]),
            .pressed   (pressed[gi]),
            .released  (released[gi]),
            .toggle    (toggle[gi]),
            .long_press(long_press[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_button_input.sv
// Scoreboard bench for button_input: run-length reference model predicts every cycle's outputs.
module tb_button_input;

   localparam int N = 2;
   localparam int D = 4;
   localparam int L = 10;
   localparam logic [N-1:0] TINIT = 2'b00;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] btn_n = '1;
   logic [N-1:0] level, pressed, released, toggle, long_press;

   typedef struct packed {
      logic [N-1:0] level;
      logic [N-1:0] pressed;
      logic [N-1:0] released;
      logic [N-1:0] toggle;
      logic [N-1:0] long_press;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   n_press = 0;
   int   n_long = 0;
   int   cycle = 0;

   always #21 clk = ~clk;

   button_input #(
      .N_BTN            (N),
      .DEBOUNCE_CYCLES  (D),
      .TOGGLE_INIT      (TINIT),
      .LONG_PRESS_CYCLES(L)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_n     (btn_n),
      .level     (level),
      .pressed   (pressed),
      .released  (released),
      .toggle    (toggle),
      .long_press(long_press)
   );

   // Reference: pins reach the decision logic two edges late; a level is accepted once the
   // sampled value has disagreed with the current level for D+1 consecutive edges.
   initial begin
      logic [N-1:0] p1, p2, s, m_level, m_toggle, pr, rl, lp;
      int  run [N];
      int  hold [N];
      bit  done [N];
      bit  was_down;
      p1 = '1; p2 = '1; m_level = '0; m_toggle = TINIT;
      for (int i = 0; i < N; i++) begin run[i] = 0; hold[i] = 0; done[i] = 0; end
      forever begin
         @(posedge clk);
         cycle++;
         pr = '0; rl = '0; lp = '0;
         if (reset) begin
            p1 = '1; p2 = '1; m_level = '0; m_toggle = TINIT;
            for (int i = 0; i < N; i++) begin run[i] = 0; hold[i] = 0; done[i] = 0; end
         end else begin
            s  = ~p2;
            p2 = p1;
            p1 = btn_n;
            for (int i = 0; i < N; i++) begin
               was_down = m_level[i] && (run[i] == 0);
               if (s[i] != m_level[i]) begin
                  run[i]++;
                  if (run[i] == D + 1) begin
                     run[i] = 0;
                     m_level[i] = s[i];
                     if (s[i]) begin
                        pr[i] = 1'b1;
                        m_toggle[i] = ~m_toggle[i];
                        n_press++;
                     end else begin
                        rl[i] = 1'b1;
                     end
                  end
               end else begin
                  run[i] = 0;
               end
               if (was_down && s[i]) begin
                  if (!done[i]) begin
                     if (hold[i] == L - 1) begin
                        lp[i] = 1'b1;
                        done[i] = 1'b1;
                     end else begin
                        hold[i]++;
                     end
                  end
               end else begin
                  hold[i] = 0;
                  done[i] = 0;
               end
            end
         end
`ifdef BUTTON_INPUT_LONG_PRESS_EN
         if (lp != '0) n_long++;
`else
         lp = '0;
`endif
         exp_q.push_back({m_level, pr, rl, m_toggle, lp});
      end
   end

   // Monitor: outputs are registered every cycle, so one expectation is consumed per cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({level, pressed, released, toggle, long_press} !== e) begin
               miscompares++;
               $display("FAIL outputs cycle %0d: got lvl=%b prs=%b rel=%b tgl=%b lp=%b, expected lvl=%b prs=%b rel=%b tgl=%b lp=%b",
                        cycle, level, pressed, released, toggle, long_press,
                        e.level, e.pressed, e.released, e.toggle, e.long_press);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hold_btn(input logic [N-1:0] b, input int n);
      btn_n = b;
      cyc(n);
   endtask

   initial begin
      cyc(3);
      reset = 1'b0;
      hold_btn(2'b11, 5);
      // clean press and release
      hold_btn(2'b10, 12);
      hold_btn(2'b11, 12);
      // glitch shorter than the debounce window
      hold_btn(2'b10, 3);
      hold_btn(2'b11, 10);
      // bounce then hold
      hold_btn(2'b10, 1); hold_btn(2'b11, 1); hold_btn(2'b10, 1); hold_btn(2'b11, 1);
      hold_btn(2'b10, 12);
      hold_btn(2'b11, 12);
      // simultaneous, then overlapping presses
      hold_btn(2'b00, 12);
      hold_btn(2'b11, 12);
      hold_btn(2'b10, 10);
      hold_btn(2'b00, 10);
      hold_btn(2'b11, 12);
      // reset mid-debounce, button held through reset release
      hold_btn(2'b10, 3);
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(12);
      hold_btn(2'b11, 12);
      // long hold
      hold_btn(2'b10, 30);
      hold_btn(2'b11, 12);
      // randomized patterns with occasional resets
      repeat (400) begin
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b1;
            cyc($urandom_range(1, 3));
            reset = 1'b0;
         end
         if ($urandom_range(0, 9) == 0)
            hold_btn(N'($urandom_range(0, 3)), $urandom_range(10, 25));
         else
            hold_btn(N'($urandom_range(0, 3)), $urandom_range(1, 9));
      end
      hold_btn(2'b11, 15);
      #1;
      vectors++;
      if (n_press < 10) begin
         miscompares++;
         $display("FAIL activity: got %0d accepted presses, required at least 10", n_press);
      end
`ifdef BUTTON_INPUT_LONG_PRESS_EN
      vectors++;
      if (n_long == 0) begin
         miscompares++;
         $display("FAIL long_activity: got %0d long presses, required at least 1", n_long);
      end
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
